// File: rtl/spi_lcd_phy_arb_pkg.sv
// Shared types and helpers for the LCD PHY arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM state (IDLE between owners, GRANT while a port owns the PHY)
//   idx_w()     : width of an index into an n-entry vector (minimum 1 bit)
package spi_lcd_phy_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_lcd_phy_arb_pick.sv
// Combinational round-robin picker (module arb_rr_pick).
// Scans i_req upward from (i_last+1) mod N, wrapping, and returns the first
// set requester as a one-hot vector.
//   i_req    in  N    request vector
//   i_last   in  LW   index of the previous owner
//   o_onehot out N    one-hot winner, 0 when no request
//   o_any    out 1    at least one request present
module arb_rr_pick
  import spi_lcd_phy_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]        i_req,
  input  logic [idx_w(N)-1:0] i_last,
  output logic [N-1:0]        o_onehot,
  output logic                o_any
);

  logic w_found;

  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    // Priority distance k = 1..N from the last owner; the nearest request wins.
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!w_found && (i == ((32'(i_last) + k) % N)) && i_req[i]) begin
          o_onehot[i] = 1'b1;
          w_found     = 1'b1;
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/spi_lcd_phy_arb.sv
// Round-robin arbiter sharing one LCD PHY byte stream between N_PORTS producers.
// A grant covers a whole locked transaction and is always followed by one IDLE
// cycle before the next owner. Optional idle timeout force-releases a port that
// holds its lock without sending bytes.
//   clk, rst   : clock, synchronous active-high reset
//   req_data   : byte for port i at [8*i+:8]
//   req_rs     : RS bit per port (0 = command, 1 = data)
//   req_valid  : byte valid per port
//   req_ready  : byte accepted per port (only the owner sees phy_ready)
//   req_lock   : port is inside a transaction
//   phy_data/phy_rs/phy_valid/phy_ready : PHY-side byte stream
//   grant      : one-hot current owner, 0 when idle
//   err_to     : sticky forced-release flag, cleared only by rst
module spi_lcd_phy_arb
  import spi_lcd_phy_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDLE_TO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_PORTS-1:0] req_data,
  input  logic [N_PORTS-1:0]   req_rs,
  input  logic [N_PORTS-1:0]   req_valid,
  output logic [N_PORTS-1:0]   req_ready,
  input  logic [N_PORTS-1:0]   req_lock,
  output logic [7:0]           phy_data,
  output logic                 phy_rs,
  output logic                 phy_valid,
  input  logic                 phy_ready,
  output logic [N_PORTS-1:0]   grant,
  output logic                 err_to
);

  localparam int unsigned LW      = idx_w(N_PORTS);
  localparam int unsigned CW      = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;
  localparam bit          TO_EN   = (IDLE_TO > 0);
  localparam logic [CW-1:0] CNT_MAX = CW'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);

  arb_state_e          r_state, w_state_nxt;
  logic [N_PORTS-1:0]  r_grant, w_grant_nxt;
  logic [LW-1:0]       r_last, w_last_nxt;
  logic [CW-1:0]       r_idle_cnt, w_idle_cnt_nxt;
  logic                r_err_to, w_err_to_nxt;

  logic [N_PORTS-1:0]  w_pick;
  logic                w_any;
  logic [LW-1:0]       w_gidx;
  logic                w_gvalid, w_glock, w_release, w_timeout;

  arb_rr_pick #(.N(N_PORTS)) u_pick (
    .i_req    (req_lock | req_valid),
    .i_last   (r_last),
    .o_onehot (w_pick),
    .o_any    (w_any)
  );

  // Owner index and AND-OR output mux on the one-hot grant.
  always_comb begin
    w_gidx    = '0;
    phy_data  = '0;
    phy_rs    = 1'b0;
    phy_valid = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (r_grant[i]) w_gidx = LW'(i);
      phy_data  = phy_data  | (req_data[8*i +: 8] & {8{r_grant[i]}});
      phy_rs    = phy_rs    | (req_rs[i]    & r_grant[i]);
      phy_valid = phy_valid | (req_valid[i] & r_grant[i]);
    end
  end

  assign req_ready = r_grant & {N_PORTS{phy_ready}};
  assign grant     = r_grant;
  assign err_to    = r_err_to;

  assign w_gvalid  = |(req_valid & r_grant);
  assign w_glock   = |(req_lock & r_grant);
  // Never release while the owner's byte is still waiting on the PHY.
  assign w_release = ~w_glock & ~(w_gvalid & ~phy_ready);
  assign w_timeout = TO_EN & w_glock & ~w_gvalid & (r_idle_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_idle_cnt_nxt = r_idle_cnt;
    w_err_to_nxt   = r_err_to;
    unique case (r_state)
      ST_IDLE: begin
        w_idle_cnt_nxt = '0;
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_release || w_timeout) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_last_nxt     = w_gidx;
          w_idle_cnt_nxt = '0;
          w_err_to_nxt   = r_err_to | w_timeout;
        end else if (w_gvalid) begin
          w_idle_cnt_nxt = '0;
        end else if (TO_EN && w_glock && (r_idle_cnt != CNT_MAX)) begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_last     <= LW'(N_PORTS - 1);
      r_idle_cnt <= '0;
      r_err_to   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_err_to   <= w_err_to_nxt;
    end
  end

endmodule

// File: tb/tb_spi_lcd_phy_arb.sv
// Directed self-checking bench for spi_lcd_phy_arb (N_PORTS=2, IDLE_TO=8).
module tb_spi_lcd_phy_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data;
  logic [1:0]  req_rs, req_valid, req_ready, req_lock, grant;
  logic [7:0]  phy_data;
  logic        phy_rs, phy_valid, phy_ready, err_to;

  int tests = 0;
  int fails = 0;

  logic [7:0] cap_data[$];
  logic       cap_rs[$];

  spi_lcd_phy_arb #(.N_PORTS(2), .IDLE_TO(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_rs    (req_rs),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lock  (req_lock),
    .phy_data  (phy_data),
    .phy_rs    (phy_rs),
    .phy_valid (phy_valid),
    .phy_ready (phy_ready),
    .grant     (grant),
    .err_to    (err_to)
  );

  always #5 clk = ~clk;

  // Record every byte the PHY accepts (sampled mid-cycle, stable before the edge).
  always @(negedge clk) begin
    if (!rst && phy_valid && phy_ready) begin
      cap_data.push_back(phy_data);
      cap_rs.push_back(phy_rs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_data  = '0;
    req_rs    = '0;
    req_valid = '0;
    req_lock  = '0;
    phy_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1: quiet after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_grant", 32'(grant), 32'h0);
      check("t1_phy_valid", 32'(phy_valid), 32'h0);
      check("t1_req_ready", 32'(req_ready), 32'h0);
    end
    check("t1_err_to", 32'(err_to), 32'h0);

    // 2: port0 three-byte transaction
    cap_data.delete();
    cap_rs.delete();
    req_lock  = 2'b01;
    req_valid = 2'b01;
    req_data  = 16'h002A;
    req_rs    = 2'b00;
    #1;
    check("t2_grant_pre", 32'(grant), 32'h0);
    tick();
    check("t2_grant", 32'(grant), 32'h1);
    check("t2_phy_valid", 32'(phy_valid), 32'h1);
    check("t2_b0_data", 32'(phy_data), 32'h2A);
    check("t2_b0_rs", 32'(phy_rs), 32'h0);
    check("t2_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_data = 16'h0000;
    req_rs   = 2'b01;
    #1;
    check("t2_b1_data", 32'(phy_data), 32'h00);
    check("t2_b1_rs", 32'(phy_rs), 32'h1);
    tick();
    req_data = 16'h003F;
    req_lock = 2'b00;
    #1;
    check("t2_b2_data", 32'(phy_data), 32'h3F);
    check("t2_grant_held", 32'(grant), 32'h1);
    tick();
    check("t2_release", 32'(grant), 32'h0);
    check("t2_phy_valid_idle", 32'(phy_valid), 32'h0);
    check("t2_ready_idle", 32'(req_ready), 32'h0);
    req_valid = 2'b00;
    check("t2_count", 32'(cap_data.size()), 32'd3);
    if (cap_data.size() == 3) begin
      check("t2_cap0", 32'(cap_data[0]), 32'h2A);
      check("t2_cap1", 32'(cap_data[1]), 32'h00);
      check("t2_cap2", 32'(cap_data[2]), 32'h3F);
      check("t2_cap_rs", {29'd0, cap_rs[2], cap_rs[1], cap_rs[0]}, 32'b110);
    end
    tick();

    // 3: repeated ties alternate starting at port0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = 16'h2010;
    req_rs   = 2'b00;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] exp_g;
      exp_g     = (r % 2 == 0) ? 2'b01 : 2'b10;
      req_lock  = 2'b11;
      req_valid = 2'b11;
      tick();
      check("t3_grant", 32'(grant), 32'(exp_g));
      check("t3_data", 32'(phy_data), (r % 2 == 0) ? 32'h10 : 32'h20);
      check("t3_ready", 32'(req_ready), 32'(exp_g));
      req_lock = ~exp_g;
      tick();
      check("t3_bubble", 32'(grant), 32'h0);
    end
    req_lock  = 2'b00;
    req_valid = 2'b00;
    tick();

    // 4: backpressure with lock already dropped
    cap_data.delete();
    cap_rs.delete();
    phy_ready = 1'b0;
    req_lock  = 2'b01;
    req_valid = 2'b01;
    req_data  = 16'h0055;
    req_rs    = 2'b01;
    tick();
    check("t4_grant", 32'(grant), 32'h1);
    req_lock = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold", 32'(grant), 32'h1);
      check("t4_data", 32'(phy_data), 32'h55);
      check("t4_ready_low", 32'(req_ready), 32'h0);
    end
    phy_ready = 1'b1;
    #1;
    check("t4_ready_high", 32'(req_ready), 32'h1);
    tick();
    check("t4_release", 32'(grant), 32'h0);
    req_valid = 2'b00;
    check("t4_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() == 1) check("t4_cap", 32'(cap_data[0]), 32'h55);
    tick();

    // 5: idle timeout on port0 while port1 waits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_lock  = 2'b01;
    req_valid = 2'b00;
    tick();
    check("t5_grant0", 32'(grant), 32'h1);
    req_lock  = 2'b11;
    req_valid = 2'b10;
    req_data  = 16'h7700;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t5_hold", 32'(grant), 32'h1);
      check("t5_err_low", 32'(err_to), 32'h0);
      check("t5_p1_ready", 32'(req_ready), 32'h1);
    end
    tick();
    check("t5_forced", 32'(grant), 32'h0);
    check("t5_err_set", 32'(err_to), 32'h1);
    tick();
    check("t5_grant1", 32'(grant), 32'h2);
    check("t5_data1", 32'(phy_data), 32'h77);
    tick();
    tick();
    check("t5_err_sticky", 32'(err_to), 32'h1);

    // 6: reset mid-burst on port1
    check("t6_pre_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    tick();
    check("t6_grant", 32'(grant), 32'h0);
    check("t6_phy_valid", 32'(phy_valid), 32'h0);
    check("t6_err", 32'(err_to), 32'h0);
    rst       = 1'b0;
    req_lock  = 2'b11;
    req_valid = 2'b11;
    tick();
    check("t6_tie", 32'(grant), 32'h1);
    req_lock  = 2'b00;
    req_valid = 2'b00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
